// File: rtl/cgra_kernel_loader.sv
// Kernel image loader: copies len 32-bit words from system memory into CGRA
// context memory, one read followed by one write per word, with sticky abort.
module cgra_kernel_loader #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  aborted_o,
    output logic [LEN_WIDTH-1:0]  words_done_o,
    output logic                  rd_req_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic                  rd_gnt_i,
    input  logic                  rd_rvalid_i,
    input  logic [DATA_WIDTH-1:0] rd_rdata_i,
    output logic                  cm_req_o,
    output logic [ADDR_WIDTH-1:0] cm_add_o,
    output logic                  cm_we_o,
    output logic [3:0]            cm_be_o,
    output logic [DATA_WIDTH-1:0] cm_wdata_o,
    input  logic                  cm_gnt_i,
    input  logic                  cm_rvalid_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        DONE    = 3'd5
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(3'd4);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  words_q, words_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  abort_q, abort_d;
    logic                  aborted_q, aborted_d;

    logic                  busy_q, done_q, rd_req_q, cm_req_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q, cm_add_q;
    logic [DATA_WIDTH-1:0] cm_wdata_q;

    logic [LEN_WIDTH-1:0]  words_inc_s;
    logic                  abort_now_s;
    logic                  unused_addr_lsb_s;

    assign words_inc_s       = words_q + LEN_WIDTH'(1'b1);
    assign abort_now_s       = abort_q | abort_i;
    assign unused_addr_lsb_s = ^{src_addr_i[1:0], dst_addr_i[1:0]};

    // Next-state logic: sequencing, pointer advance and sticky abort capture.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        words_d   = words_q;
        data_d    = data_q;
        abort_d   = abort_q;
        aborted_d = aborted_q;

        if ((state_q inside {RD_REQ, RD_WAIT, WR_REQ, WR_WAIT}) && abort_i) begin
            abort_d = 1'b1;
        end else begin
            abort_d = abort_q;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_d     = {src_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    dst_d     = {dst_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    len_d     = len_i;
                    words_d   = '0;
                    abort_d   = 1'b0;
                    aborted_d = 1'b0;
                    if (len_i != '0) begin
                        state_d = RD_REQ;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                if (rd_gnt_i) begin
                    state_d = RD_WAIT;
                end else begin
                    state_d = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (rd_rvalid_i) begin
                    data_d  = rd_rdata_i;
                    state_d = WR_REQ;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            WR_REQ: begin
                if (cm_gnt_i) begin
                    state_d = WR_WAIT;
                end else begin
                    state_d = WR_REQ;
                end
            end
            WR_WAIT: begin
                if (cm_rvalid_i) begin
                    words_d = words_inc_s;
                    src_d   = src_q + WORD_STEP;
                    dst_d   = dst_q + WORD_STEP;
                    // An abort raised in this very cycle still counts.
                    if ((words_inc_s == len_q) || abort_now_s) begin
                        aborted_d = abort_now_s;
                        state_d   = DONE;
                    end else begin
                        state_d   = RD_REQ;
                    end
                end else begin
                    state_d = WR_WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Internal state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            words_q   <= '0;
            data_q    <= '0;
            abort_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            words_q   <= words_d;
            data_q    <= data_d;
            abort_q   <= abort_d;
            aborted_q <= aborted_d;
        end
    end

    // Registered bus/status outputs decoded from the next state; addresses
    // and write data only load on entry to their request state, so they hold
    // steady until grant and keep their last value afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_req_q   <= 1'b0;
            cm_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            cm_add_q   <= '0;
            cm_wdata_q <= '0;
        end else begin
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
            rd_req_q <= (state_d == RD_REQ);
            cm_req_q <= (state_d == WR_REQ);
            if (state_d == RD_REQ) begin
                rd_addr_q <= src_d;
            end else begin
                rd_addr_q <= rd_addr_q;
            end
            if (state_d == WR_REQ) begin
                cm_add_q   <= dst_d;
                cm_wdata_q <= data_d;
            end else begin
                cm_add_q   <= cm_add_q;
                cm_wdata_q <= cm_wdata_q;
            end
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign aborted_o    = aborted_q;
    assign words_done_o = words_q;
    assign rd_req_o     = rd_req_q;
    assign rd_addr_o    = rd_addr_q;
    assign cm_req_o     = cm_req_q;
    assign cm_add_o     = cm_add_q;
    assign cm_we_o      = cm_req_q;
    assign cm_be_o      = 4'hF;
    assign cm_wdata_o   = cm_wdata_q;

endmodule

// File: tb/tb_cgra_kernel_loader.sv
// Self-checking bench for cgra_kernel_loader: bus slaves with configurable
// grant delays, a transfer-level reference model and a per-cycle checker.
module tb_cgra_kernel_loader;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i, abort_i;
    logic [31:0] src_addr_i, dst_addr_i;
    logic [15:0] len_i;
    logic        busy_o, done_o, aborted_o;
    logic [15:0] words_done_o;
    logic        rd_req_o, rd_gnt_i, rd_rvalid_i;
    logic [31:0] rd_addr_o, rd_rdata_i;
    logic        cm_req_o, cm_we_o, cm_gnt_i, cm_rvalid_i;
    logic [31:0] cm_add_o, cm_wdata_o;
    logic [3:0]  cm_be_o;

    always #5 clk_i = ~clk_i;

    cgra_kernel_loader dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
        .aborted_o(aborted_o), .words_done_o(words_done_o),
        .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_gnt_i(rd_gnt_i),
        .rd_rvalid_i(rd_rvalid_i), .rd_rdata_i(rd_rdata_i),
        .cm_req_o(cm_req_o), .cm_add_o(cm_add_o), .cm_we_o(cm_we_o),
        .cm_be_o(cm_be_o), .cm_wdata_o(cm_wdata_o), .cm_gnt_i(cm_gnt_i),
        .cm_rvalid_i(cm_rvalid_i)
    );

    int checks = 0;
    int passed = 0;
    int mode   = 0;          // 0 zero-wait, 1 fixed rd=3/cm=2, 2 random
    logic [31:0] exp_addr[$], exp_data[$], got_addr[$], got_data[$];
    int rd_cnt, wr_closed, rd_left, cm_left;
    int last_words, last_aborted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a >= 32'h0000_1000 && a < 32'h0000_1010) return 32'hA0 + ((a - 32'h0000_1000) >> 2);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic int pick_rd();
        if (mode == 0) return 0;
        if (mode == 1) return 3;
        return int'($urandom_range(0, 3));
    endfunction

    function automatic int pick_cm();
        if (mode == 0) return 0;
        if (mode == 1) return 2;
        return int'($urandom_range(0, 3));
    endfunction

    // Bus slaves plus per-cycle rule checker and write scoreboard.
    initial begin
        bit          rd_pend = 1'b0, cm_pend = 1'b0, rd_hold = 1'b0, cm_hold = 1'b0;
        logic [31:0] rd_pend_addr = 32'h0, rd_hold_addr = 32'h0;
        logic [31:0] cm_hold_addr = 32'h0, cm_hold_data = 32'h0;
        logic [7:0]  err;
        rd_gnt_i = 1'b0; rd_rvalid_i = 1'b0; rd_rdata_i = 32'h0;
        cm_gnt_i = 1'b0; cm_rvalid_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                rd_pend = 1'b0; cm_pend = 1'b0; rd_hold = 1'b0; cm_hold = 1'b0;
                rd_gnt_i = 1'b0; rd_rvalid_i = 1'b0; cm_gnt_i = 1'b0; cm_rvalid_i = 1'b0;
                rd_left = 0; cm_left = 0;
                continue;
            end
            err[0] = (cm_we_o != cm_req_o);
            err[1] = (cm_be_o != 4'hF);
            err[2] = (rd_addr_o[1:0] != 2'b00);
            err[3] = (cm_add_o[1:0] != 2'b00);
            err[4] = !busy_o && (rd_req_o || cm_req_o);
            err[5] = rd_hold && (!rd_req_o || rd_addr_o != rd_hold_addr);
            err[6] = cm_hold && (!cm_req_o || cm_add_o != cm_hold_addr || cm_wdata_o != cm_hold_data);
            err[7] = rd_req_o && cm_req_o;
            chk("bus_rules", {24'h0, err}, 32'h0);

            rd_rvalid_i = rd_pend;
            if (rd_pend) rd_rdata_i = memf(rd_pend_addr);
            rd_pend = 1'b0;
            cm_rvalid_i = cm_pend;
            if (cm_pend) wr_closed++;
            cm_pend = 1'b0;
            rd_gnt_i = 1'b0; cm_gnt_i = 1'b0; rd_hold = 1'b0; cm_hold = 1'b0;

            if (rd_req_o) begin
                if (rd_left == 0) begin
                    rd_gnt_i = 1'b1; rd_pend = 1'b1; rd_pend_addr = rd_addr_o;
                    rd_cnt++; rd_left = pick_rd();
                end else begin
                    rd_left--; rd_hold = 1'b1; rd_hold_addr = rd_addr_o;
                end
            end
            if (cm_req_o) begin
                if (cm_left == 0) begin
                    cm_gnt_i = 1'b1; cm_pend = 1'b1; cm_left = pick_cm();
                    if (got_addr.size() < exp_addr.size()) begin
                        chk("wr_addr", cm_add_o, exp_addr[got_addr.size()]);
                        chk("wr_data", cm_wdata_o, exp_data[got_addr.size()]);
                    end else begin
                        chk("extra_write", 32'd1, 32'd0);
                    end
                    got_addr.push_back(cm_add_o);
                    got_data.push_back(cm_wdata_o);
                end else begin
                    cm_left--; cm_hold = 1'b1;
                    cm_hold_addr = cm_add_o; cm_hold_data = cm_wdata_o;
                end
            end
        end
    end

    // One transfer against the model; entered and left at posedge+1.
    // cost>0 is the per-word cycle cost to check latency against.
    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input int abort_cyc, input int cost, input bit glitch);
        int k = -1;
        int n;
        int c;
        exp_addr.delete(); exp_data.delete(); got_addr.delete(); got_data.delete();
        for (int i = 0; i < len; i++) begin
            exp_addr.push_back((dst & 32'hFFFF_FFFC) + 32'(4 * i));
            exp_data.push_back(memf((src & 32'hFFFF_FFFC) + 32'(4 * i)));
        end
        rd_cnt = 0; wr_closed = 0; rd_left = pick_rd(); cm_left = pick_cm();
        start_i = 1'b1; src_addr_i = src; dst_addr_i = dst; len_i = 16'(len);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        c = 1;
        chk("busy_rise", {31'h0, busy_o}, 32'd1);
        while (c < 3000) begin
            start_i = glitch && (c == 2);
            if (start_i) begin
                src_addr_i = ~src; len_i = 16'(len + 5);
            end
            if (c == abort_cyc) begin
                abort_i = 1'b1;
                if (busy_o && !done_o) k = wr_closed;
            end else begin
                abort_i = 1'b0;
            end
            if (done_o) break;
            @(posedge clk_i); #1;
            c++;
        end
        if (c >= 3000) begin
            chk("done_timeout", 32'd0, 32'd1);
            abort_i = 1'b0; start_i = 1'b0;
            return;
        end
        n = (k >= 0 && k + 1 < len) ? k + 1 : len;
        last_words = int'(words_done_o);
        last_aborted = int'(aborted_o);
        chk("words_done", {16'h0, words_done_o}, 32'(n));
        chk("aborted", {31'h0, aborted_o}, {31'h0, k >= 0});
        chk("write_count", 32'(got_addr.size()), 32'(n));
        chk("read_count", 32'(rd_cnt), 32'(n));
        if (cost > 0) chk("latency", 32'(c), 32'(1 + cost * n));
        abort_i = 1'b0;
        start_i = glitch;      // start during the DONE cycle must be ignored
        @(posedge clk_i); #1;
        start_i = 1'b0;
        chk("idle_after_done", {30'h0, busy_o, done_o}, 32'd0);
        chk("aborted_hold", {31'h0, aborted_o}, {31'h0, k >= 0});
        if (glitch) begin
            @(posedge clk_i); #1;
            chk("start_in_done_ignored", {31'h0, busy_o}, 32'd0);
        end
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        src_addr_i = 32'h0; dst_addr_i = 32'h0; len_i = 16'h0;
        #1;
        chk("reset_strobes", {26'h0, busy_o, done_o, aborted_o, rd_req_o, cm_req_o, cm_we_o}, 32'h0);
        chk("reset_words", {16'h0, words_done_o}, 32'h0);
        chk("reset_addr", rd_addr_o | cm_add_o | cm_wdata_o, 32'h0);
        chk("reset_be", {28'h0, cm_be_o}, 32'hF);
        chk("model_pin_mem", memf(32'h0000_1008), 32'h0000_00A2);
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Basic copy, zero-wait.
        mode = 0;
        run_xfer(32'h0000_1000, 32'h0000_0000, 4, -1, 4, 1'b0);
        chk("basic_addr3", got_addr[3], 32'h0000_000C);
        chk("basic_data0", got_data[0], 32'h0000_00A0);
        chk("basic_data3", got_data[3], 32'h0000_00A3);
        chk("basic_words", 32'(last_words), 32'd4);

        // Zero length.
        run_xfer(32'h0000_2000, 32'h0000_0100, 0, -1, 4, 1'b0);
        chk("zero_len_writes", 32'(got_addr.size()), 32'd0);

        // Back-pressure: rd grant 3 late, cm grant 2 late.
        mode = 1;
        run_xfer(32'h0000_1000, 32'h0000_0040, 2, -1, 9, 1'b0);
        chk("bp_data1", got_data[1], 32'h0000_00A1);

        // Abort during the second word's RD_WAIT.
        mode = 0;
        run_xfer(32'h0000_3000, 32'h0000_0200, 8, 6, 4, 1'b0);
        chk("abort_words", 32'(last_words), 32'd2);
        chk("abort_flag", 32'(last_aborted), 32'd1);

        // Wrap and alignment.
        run_xfer(32'h0000_1003, 32'hFFFF_FFFE, 2, -1, 4, 1'b0);
        chk("wrap_addr0", got_addr[0], 32'hFFFF_FFFC);
        chk("wrap_addr1", got_addr[1], 32'h0000_0000);

        // Start while busy and start during DONE are ignored.
        run_xfer(32'h0000_4000, 32'h0000_0300, 3, -1, 4, 1'b1);

        // Reset during WR_REQ.
        exp_addr.delete(); exp_data.delete(); got_addr.delete(); got_data.delete();
        exp_addr.push_back(32'h0000_0500); exp_data.push_back(memf(32'h0000_5000));
        rd_left = 0; cm_left = 0;
        start_i = 1'b1; src_addr_i = 32'h0000_5000; dst_addr_i = 32'h0000_0500; len_i = 16'd3;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cm_req_o) break;
            @(posedge clk_i); #1;
        end
        chk("reached_wr_req", {31'h0, cm_req_o}, 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("reset_mid_xfer", {29'h0, cm_req_o, busy_o, rd_req_o}, 32'h0);
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        run_xfer(32'h0000_6000, 32'h0000_0600, 1, -1, 4, 1'b0);

        // Randomized transfers.
        for (int t = 0; t < 14; t++) begin
            int len, ab, cost;
            mode = int'($urandom_range(0, 2));
            len  = int'($urandom_range(0, 6));
            ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : -1;
            cost = (mode == 0) ? 4 : ((mode == 1) ? 9 : 0);
            run_xfer($urandom, $urandom, len, ab, cost, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
